// File: rtl/bcd_ndigit_pkg.sv
// rtl/bcd_ndigit_pkg.sv - shared state encoding, blank code and latency helper for bcd_ndigit
package bcd_ndigit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_STORE  = 2'd3
    } state_e;

    localparam logic [3:0] BCD_BLANK  = 4'hF;
    localparam int         MAX_DIGITS = 8;

    function automatic int calc_latency(input int digits, input int width);
        return digits * (width + 1);
    endfunction

endpackage

// File: rtl/bcd_ndigit_divmod10_seq.sv
// rtl/bcd_ndigit_divmod10_seq.sv - restoring divide-by-10, one quotient bit per cycle
module divmod10_seq #(
    parameter int WIDTH = 14
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [3:0]       remainder_o,
    output logic             valid_o
);
    localparam int SW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] quo_q, quo_d;
    logic [3:0]       rem_q, rem_d;
    logic [SW-1:0]    step_q, step_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] src;
    logic [3:0]       rem_in;
    logic [4:0]       trial;
    logic             qbit;

    // The start edge already resolves the MSB, so WIDTH-1 further steps finish the job.
    always_comb begin
        src     = start_i ? dividend_i : quo_q;
        rem_in  = start_i ? 4'd0 : rem_q;
        trial   = {rem_in, src[WIDTH-1]};
        qbit    = (trial >= 5'd10);
        quo_d   = quo_q;
        rem_d   = rem_q;
        step_d  = step_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        if (start_i || busy_q) begin
            rem_d = qbit ? (trial[3:0] - 4'd10) : trial[3:0];
            quo_d = {src[WIDTH-2:0], qbit};
            if (start_i) begin
                busy_d = 1'b1;
                step_d = SW'(1);
            end else begin
                step_d = step_q + SW'(1);
                if (step_q == SW'(WIDTH - 1)) begin
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            quo_q   <= '0;
            rem_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;
    assign valid_o     = valid_q;

endmodule

// File: rtl/bcd_ndigit.sv
// rtl/bcd_ndigit.sv - iterative binary-to-BCD converter; BCD_NDIGIT_BLANK_EN enables leading-zero blanking
module bcd_ndigit
    import bcd_ndigit_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      value_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   digits_o,
    output logic                  overflow_o
);
    localparam int CW = $clog2(WIDTH);

    state_e              state_q;
    logic [WIDTH-1:0]    dvd_q;
    logic [3:0]          cnt_q;
    logic [CW-1:0]       div_cnt_q;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [4*DIGITS-1:0] pub_d;
    logic                ready_q, done_q, ovf_q;
    logic [4*DIGITS-1:0] digits_q;
    logic                div_start;
    logic [WIDTH-1:0]    div_quo;
    logic [3:0]          div_rem;
    logic                div_valid;
    logic                lead;

    assign div_start = (state_q == ST_LOAD);

    divmod10_seq #(.WIDTH(WIDTH)) u_div (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (div_start),
        .dividend_i  (dvd_q),
        .quotient_o  (div_quo),
        .remainder_o (div_rem),
        .valid_o     (div_valid)
    );

    // Shadow with the digit being stored merged in, so publish sees the full result.
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == 4'(i)) shadow_d[4*i +: 4] = div_rem;
        end
        pub_d = shadow_d;
        lead  = 1'b1;
        if (|div_quo) begin
            pub_d = {DIGITS{4'h9}};
        end else begin
`ifdef BCD_NDIGIT_BLANK_EN
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (lead && shadow_d[4*i +: 4] == 4'd0) pub_d[4*i +: 4] = BCD_BLANK;
                else lead = 1'b0;
            end
`else
            lead = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            dvd_q     <= '0;
            cnt_q     <= '0;
            div_cnt_q <= '0;
            shadow_q  <= {DIGITS{BCD_BLANK}};
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            digits_q  <= {DIGITS{BCD_BLANK}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        dvd_q   <= value_i;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    div_cnt_q <= '0;
                    state_q   <= ST_DIVIDE;
                end
                ST_DIVIDE: begin
                    if (div_cnt_q == CW'(WIDTH - 2)) state_q <= ST_STORE;
                    else div_cnt_q <= div_cnt_q + CW'(1);
                end
                ST_STORE: begin
                    if (div_valid) begin
                        shadow_q <= shadow_d;
                        dvd_q    <= div_quo;
                        cnt_q    <= cnt_q + 4'd1;
                        if (cnt_q == 4'(DIGITS - 1)) begin
                            state_q  <= ST_IDLE;
                            ready_q  <= 1'b1;
                            done_q   <= 1'b1;
                            digits_q <= pub_d;
                            ovf_q    <= |div_quo;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready_o    = ready_q;
    assign done_o     = done_q;
    assign digits_o   = digits_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_bcd_ndigit.sv
// tb/tb_bcd_ndigit.sv - randomized self-checking bench for bcd_ndigit against an arithmetic model
module tb_bcd_ndigit;
    import bcd_ndigit_pkg::*;

    localparam int D  = 4;
    localparam int W  = 14;
    localparam int D5 = 5;
    localparam int W5 = 17;
`ifdef BCD_NDIGIT_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            start5 = 1'b0;
    logic [W-1:0]    value = '0;
    logic [W5-1:0]   value5 = '0;
    logic            ready, done, overflow;
    logic [4*D-1:0]  digits;
    logic            ready5, done5, overflow5;
    logic [4*D5-1:0] digits5;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_ndigit #(.DIGITS(D), .WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .value_i(value),
        .ready_o(ready), .done_o(done), .digits_o(digits), .overflow_o(overflow)
    );

    bcd_ndigit #(.DIGITS(D5), .WIDTH(W5)) dut5 (
        .clk_i(clk), .rst_i(rst), .start_i(start5), .value_i(value5),
        .ready_o(ready5), .done_o(done5), .digits_o(digits5), .overflow_o(overflow5)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_digits(input longint unsigned v, input int nd, input bit blank);
        logic [31:0]     r;
        longint unsigned lim;
        longint unsigned t;
        bit              lead;
        r    = '0;
        lim  = 1;
        t    = v;
        lead = 1'b1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        if (v >= lim) begin
            for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'h9;
            return r;
        end
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        if (blank) begin
            for (int i = nd - 1; i >= 1; i--) begin
                if (lead && r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
                else lead = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues start now; optionally pokes a second start at busy cycle poke_at.
    task automatic run_conv(input int unsigned v, input int poke_at, input int unsigned poke_v);
        int cyc;
        bit ready_bad;
        value = W'(v);
        start = 1'b1;
        tick();
        start = 1'b0;
        value = W'($urandom);
        cyc = 0;
        ready_bad = 1'b0;
        while (!done && cyc <= 200) begin
            if (ready) ready_bad = 1'b1;
            if (cyc == poke_at) begin
                start = 1'b1;
                value = W'(poke_v);
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        check_val("latency", cyc, calc_latency(D, W));
        check_val("ready_busy", ready_bad, 1'b0);
        check_val("digits", digits, model_digits(v, D, BLANK));
        check_val("overflow", overflow, (v >= 10000));
        check_val("ready_pub", ready, 1'b1);
    endtask

    initial begin
        bit changed;
        bit seen_done;
        int cyc;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_digits", digits, 16'hFFFF);
        check_val("rst_ready", ready, 1'b1);
        check_val("rst_done", done, 1'b0);
        check_val("rst_ovf", overflow, 1'b0);
        check_val("rst_digits5", digits5, 20'hFFFFF);

        changed = 1'b0;
        repeat (100) begin
            tick();
            if (digits !== 16'hFFFF || ready !== 1'b1 || done !== 1'b0 || overflow !== 1'b0) changed = 1'b1;
        end
        check_val("idle_hold", changed, 1'b0);

        run_conv(1234, -1, 0);
        run_conv(56, -1, 0);
        tick();
        check_val("done_pulse", done, 1'b0);
        run_conv(7, -1, 0);     tick();
        run_conv(0, -1, 0);     tick();
        run_conv(12345, -1, 0); tick();
        run_conv(9999, -1, 0);  tick();
        run_conv(1234, 10, 42); tick();
        run_conv(10000, -1, 0); tick();
        run_conv(16383, -1, 0); tick();
        repeat (20) begin
            run_conv($urandom_range(0, 16383), -1, 0);
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();

        // Abort mid-conversion, with start also high during reset.
        value = W'(4321);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check_val("abort_digits", digits, 16'hFFFF);
        check_val("abort_ready", ready, 1'b1);
        check_val("abort_done", done, 1'b0);
        check_val("abort_ovf", overflow, 1'b0);
        seen_done = 1'b0;
        changed = 1'b0;
        repeat (100) begin
            if (done) seen_done = 1'b1;
            if (!ready) changed = 1'b1;
            tick();
        end
        check_val("abort_no_done", seen_done, 1'b0);
        check_val("abort_stay_idle", changed, 1'b0);
        run_conv(9999, -1, 0);

        value5 = W5'(99999);
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        cyc = 0;
        while (!done5 && cyc <= 300) begin
            tick();
            cyc++;
        end
        check_val("latency5", cyc, calc_latency(D5, W5));
        check_val("digits5", digits5, model_digits(99999, D5, BLANK));
        check_val("overflow5", overflow5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
